// File: rtl/cb_bitop_seq_pkg.sv
// Shared CPU definitions for the CB-prefixed bit-operation sequencer:
// FSM states, op classes, bit-ALU control codes, flag positions and operand codes.
package cb_bitop_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_EXEC = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OPC_ILLEGAL = 2'b00,
    OPC_BIT     = 2'b01,
    OPC_RES     = 2'b10,
    OPC_SET     = 2'b11
  } op_class_e;

  typedef enum logic [2:0] {
    ALU_RES = 3'b000,
    ALU_SET = 3'b001,
    ALU_BIT = 3'b111
  } alu_ctl_e;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  localparam logic [2:0] OPND_HL = 3'd6;

  function automatic op_class_e op_class(input logic [7:0] opcode);
    return op_class_e'(opcode[7:6]);
  endfunction

  // Illegal ops never reach EXEC, so their mapping is irrelevant.
  function automatic alu_ctl_e alu_ctl(input op_class_e cls);
    case (cls)
      OPC_RES: return ALU_RES;
      OPC_SET: return ALU_SET;
      default: return ALU_BIT;
    endcase
  endfunction

endpackage

// File: rtl/cb_bitop_seq_if.sv
// Request, register/flag writeback and memory bus signals of the CB bit-op sequencer.
interface cb_bitop_seq_if #(
  parameter int ADDR_W = 16
) ();

  logic              start;
  logic [7:0]        opcode;
  logic [7:0]        reg_rdata;
  logic [ADDR_W-1:0] hl;
  logic [7:0]        f_in;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  logic              busy;
  logic              done;
  logic              err;
  logic              reg_we;
  logic [2:0]        reg_sel;
  logic [7:0]        reg_wdata;
  logic              f_we;
  logic [7:0]        f_out;

  modport slave (
    input  start, opcode, reg_rdata, hl, f_in, mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy, done, err, reg_we, reg_sel, reg_wdata, f_we, f_out
  );

  modport master (
    output start, opcode, reg_rdata, hl, f_in, mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy, done, err, reg_we, reg_sel, reg_wdata, f_we, f_out
  );

endinterface

// File: rtl/cb_bitop_seq_bitalu.sv
// Combinational bit ALU: clear, set or test one bit of an 8-bit operand.
// BIT leaves the carry position at 0; the controller merges the held carry in.
module cb_bitop_seq_bitalu
  import cb_bitop_seq_pkg::*;
(
  input  logic [7:0] operand,
  input  logic [2:0] bit_idx,
  input  alu_ctl_e   ctl,
  output logic [7:0] result
);

  always_comb begin
    result = operand;
    case (ctl)
      ALU_RES: result[bit_idx] = 1'b0;
      ALU_SET: result[bit_idx] = 1'b1;
      ALU_BIT: begin
        result         = '0;
        result[FLAG_Z] = ~operand[bit_idx];
        result[FLAG_N] = 1'b0;
        result[FLAG_H] = 1'b1;
      end
      default: result = operand;
    endcase
  end

endmodule

// File: rtl/cb_bitop_seq.sv
// Sequencer for CB-prefixed BIT/RES/SET ops on a register or on (HL) memory,
// with register/flag writeback in the DONE cycle and memory read-modify-write.
module cb_bitop_seq
  import cb_bitop_seq_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input logic            clk,
  input logic            reset,
  cb_bitop_seq_if.slave  bus
);

  state_e            state_q, state_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        operand_q, operand_d;
  logic [7:0]        result_q, result_d;
  logic              c_q, c_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  op_class_e  cls;
  logic       is_mem;
  alu_ctl_e   ctl;
  logic [7:0] alu_res;
  logic [7:0] exec_res;

  assign cls    = op_class(opcode_q);
  assign is_mem = (opcode_q[2:0] == OPND_HL);
  assign ctl    = alu_ctl(cls);

  cb_bitop_seq_bitalu u_bitalu (
    .operand (operand_q),
    .bit_idx (opcode_q[5:3]),
    .ctl     (ctl),
    .result  (alu_res)
  );

  // BIT keeps the caller's carry; the ALU only produces Z/N/H.
  always_comb begin
    exec_res = alu_res;
    if (cls == OPC_BIT) exec_res[FLAG_C] = c_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      operand_q <= '0;
      result_q  <= '0;
      c_q       <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      c_q       <= c_d;
      addr_q    <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    result_d  = result_q;
    c_d       = c_q;
    addr_d    = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          opcode_d  = bus.opcode;
          operand_d = bus.reg_rdata;
          c_d       = bus.f_in[FLAG_C];
          addr_d    = bus.hl;
          if (op_class(bus.opcode) == OPC_ILLEGAL) state_d = ST_DONE;
          else if (bus.opcode[2:0] == OPND_HL)     state_d = ST_RD;
          else                                     state_d = ST_EXEC;
        end
      end
      ST_RD: begin
        if (bus.mem_ack) begin
          operand_d = bus.mem_rdata;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = exec_res;
        state_d  = (is_mem && cls != OPC_BIT) ? ST_WR : ST_DONE;
      end
      ST_WR: begin
        if (bus.mem_ack) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Data outputs are gated by their strobes so they read as zero when idle.
  always_comb begin
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = (state_q == ST_DONE);
    bus.err       = (state_q == ST_DONE) && (cls == OPC_ILLEGAL);
    bus.mem_req   = (state_q == ST_RD) || (state_q == ST_WR);
    bus.mem_we    = (state_q == ST_WR);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.reg_we    = 1'b0;
    bus.reg_sel   = '0;
    bus.reg_wdata = '0;
    bus.f_we      = 1'b0;
    bus.f_out     = '0;
    if (bus.mem_req) bus.mem_addr  = addr_q;
    if (bus.mem_we)  bus.mem_wdata = result_q;
    if (state_q == ST_DONE) begin
      if (!is_mem && (cls == OPC_RES || cls == OPC_SET)) begin
        bus.reg_we    = 1'b1;
        bus.reg_sel   = opcode_q[2:0];
        bus.reg_wdata = result_q;
      end
      if (cls == OPC_BIT) begin
        bus.f_we  = 1'b1;
        bus.f_out = result_q;
      end
    end
  end

endmodule

// File: tb/tb_cb_bitop_seq.sv
// Self-checking bench for cb_bitop_seq: directed scenarios plus randomized ops
// checked against a behavioural model of BIT/RES/SET, latency and bus traffic.
module tb_cb_bitop_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cb_bitop_seq_if #(.ADDR_W(16)) bus ();

  cb_bitop_seq #(.ADDR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  int         done_cyc, n_done, n_err, n_rd, n_wr, n_regwe, n_fwe, n_req_bad, n_stray;
  logic [15:0] rd_addr, wr_addr;
  logic [7:0]  wr_data, reg_wdata_v, f_out_v;
  logic [2:0]  reg_sel_v;

  function automatic logic [7:0] model(input logic [7:0] op, input logic [7:0] v, input logic [7:0] f);
    int b;
    b = int'(op[5:3]);
    case (op[7:6])
      2'b01:   return ((((v >> b) & 8'h01) != 8'h00) ? 8'h00 : 8'h80) | 8'h20 | (f & 8'h10);
      2'b10:   return v & ~(8'h01 << b);
      2'b11:   return v | (8'h01 << b);
      default: return 8'h00;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.opcode = 8'h00; bus.reg_rdata = 8'h00; bus.hl = 16'h0000;
    bus.f_in = 8'h00; bus.mem_rdata = 8'h00; bus.mem_ack = 1'b0;
  endtask

  // Issue one op and act as memory, acking each access after dly waiting cycles.
  task automatic run_op(input logic [7:0] op, input logic [7:0] rr, input logic [15:0] h,
                        input logic [7:0] f, input logic [7:0] mrd, input int dly);
    int wait_n; logic prev_ack; logic [15:0] a0; logic [7:0] d0; logic we0;
    done_cyc = -1; n_done = 0; n_err = 0; n_rd = 0; n_wr = 0; n_regwe = 0; n_fwe = 0;
    n_req_bad = 0; n_stray = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    reg_wdata_v = '0; f_out_v = '0; reg_sel_v = '0;
    wait_n = 0; prev_ack = 1'b0; a0 = '0; d0 = '0; we0 = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opcode = op; bus.reg_rdata = rr; bus.hl = h; bus.f_in = f;
    bus.mem_rdata = ~mrd;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k;
        if (bus.err) n_err++;
      end
      if (bus.reg_we) begin n_regwe++; reg_sel_v = bus.reg_sel; reg_wdata_v = bus.reg_wdata; end
      if (bus.f_we) begin n_fwe++; f_out_v = bus.f_out; end
      if ((bus.reg_we || bus.f_we || bus.err) && !bus.done) n_stray++;
      if (bus.mem_req) begin
        if (prev_ack) n_req_bad++;
        if (wait_n == 0) begin
          a0 = bus.mem_addr; d0 = bus.mem_wdata; we0 = bus.mem_we;
        end else if (bus.mem_addr !== a0 || bus.mem_wdata !== d0 || bus.mem_we !== we0) begin
          n_req_bad++;
        end
        wait_n++;
        if (wait_n > dly) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = mrd;
          if (bus.mem_we) begin n_wr++; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata; end
          else begin n_rd++; rd_addr = bus.mem_addr; end
          wait_n = 0;
        end
      end
      prev_ack = bus.mem_ack;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = ~mrd;
      bus.reg_rdata = ~rr; bus.hl = ~h; bus.f_in = ~f; bus.opcode = 8'($urandom);
      if (done_cyc >= 0 && k >= done_cyc + 2) break;
    end
    bus.opcode = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done); else passes++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b want=0", bus.mem_req); else passes++;
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.err, bus.reg_we, bus.reg_sel,
         bus.reg_wdata, bus.f_we, bus.f_out} !== '0)
      $display("FAIL reset_outputs got we=%b addr=%h wd=%h err=%b rwe=%b sel=%0d rwd=%h fwe=%b fo=%h want all 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.err, bus.reg_we, bus.reg_sel,
               bus.reg_wdata, bus.f_we, bus.f_out);
    else passes++;
    reset = 1'b0;
  endtask

  task automatic test_reg_set();
    run_op(8'hC7, 8'h00, 16'h1234, 8'h00, 8'h00, 0);
    checks++; if (done_cyc !== 2) $display("FAIL reg_set_latency got=%0d want=2", done_cyc); else passes++;
    checks++; if (n_regwe !== 1 || reg_sel_v !== 3'd7) $display("FAIL reg_set_we got=%0d sel=%0d want=1 sel=7", n_regwe, reg_sel_v); else passes++;
    checks++; if (reg_wdata_v !== 8'h01) $display("FAIL reg_set_data got=%h want=01", reg_wdata_v); else passes++;
    checks++; if (n_fwe !== 0 || n_rd + n_wr !== 0) $display("FAIL reg_set_side got fwe=%0d acc=%0d want 0", n_fwe, n_rd + n_wr); else passes++;
  endtask

  task automatic test_bit_reg();
    run_op(8'h7C, 8'h80, 16'h0000, 8'h10, 8'h00, 0);
    checks++; if (n_fwe !== 1 || f_out_v !== 8'h30) $display("FAIL bit_set_flags got fwe=%0d f=%h want 1 f=30", n_fwe, f_out_v); else passes++;
    checks++; if (n_regwe !== 0) $display("FAIL bit_reg_we got=%0d want=0", n_regwe); else passes++;
    run_op(8'h7C, 8'h00, 16'h0000, 8'h10, 8'h00, 0);
    checks++; if (f_out_v !== 8'hB0) $display("FAIL bit_clr_flags got=%h want=B0", f_out_v); else passes++;
  endtask

  task automatic test_mem_res();
    run_op(8'h86, 8'h55, 16'hC000, 8'h00, 8'hFF, 3);
    checks++; if (n_rd !== 1 || rd_addr !== 16'hC000) $display("FAIL mem_res_read got n=%0d a=%h want 1 a=C000", n_rd, rd_addr); else passes++;
    checks++; if (n_wr !== 1 || wr_addr !== 16'hC000 || wr_data !== 8'hFE) $display("FAIL mem_res_write got n=%0d a=%h d=%h want 1 C000 FE", n_wr, wr_addr, wr_data); else passes++;
    checks++; if (n_req_bad !== 0) $display("FAIL mem_res_stable got=%0d want=0", n_req_bad); else passes++;
    checks++; if (n_done !== 1 || done_cyc !== 10) $display("FAIL mem_res_done got n=%0d cyc=%0d want 1 cyc=10", n_done, done_cyc); else passes++;
    checks++; if (n_regwe + n_fwe !== 0) $display("FAIL mem_res_strobes got=%0d want=0", n_regwe + n_fwe); else passes++;
  endtask

  task automatic test_mem_bit();
    run_op(8'h46, 8'h00, 16'h8001, 8'h00, 8'h01, 1);
    checks++; if (n_rd !== 1 || n_wr !== 0) $display("FAIL mem_bit_access got rd=%0d wr=%0d want 1 0", n_rd, n_wr); else passes++;
    checks++; if (n_fwe !== 1 || f_out_v !== 8'h20) $display("FAIL mem_bit_flags got fwe=%0d f=%h want 1 f=20", n_fwe, f_out_v); else passes++;
  endtask

  task automatic test_illegal();
    run_op(8'h00, 8'h12, 16'h4000, 8'hF0, 8'h00, 0);
    checks++; if (done_cyc !== 1 || n_err !== 1) $display("FAIL illegal_done got cyc=%0d err=%0d want 1 1", done_cyc, n_err); else passes++;
    checks++; if (n_regwe + n_fwe + n_rd + n_wr !== 0) $display("FAIL illegal_side got=%0d want=0", n_regwe + n_fwe + n_rd + n_wr); else passes++;
    run_op(8'h36, 8'h12, 16'h4000, 8'hF0, 8'h00, 0);
    checks++; if (done_cyc !== 1 || n_err !== 1 || n_rd + n_wr !== 0) $display("FAIL illegal_hl got cyc=%0d err=%0d acc=%0d want 1 1 0", done_cyc, n_err, n_rd + n_wr); else passes++;
  endtask

  task automatic test_reset_mid_wr();
    int wr_seen; int dn; int rq;
    wr_seen = 0; dn = 0; rq = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opcode = 8'hDE; bus.hl = 16'hABCD; bus.reg_rdata = 8'h00;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_req && !bus.mem_we) begin bus.mem_ack = 1'b1; bus.mem_rdata = 8'h00; end
      if (bus.mem_req && bus.mem_we) wr_seen++;
      if (wr_seen == 2) break;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.mem_ack = 1'b0;
    end
    checks++; if (wr_seen !== 2) $display("FAIL rst_wr_reached got=%0d want=2", wr_seen); else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rst_wr_abort got req=%b busy=%b want 0 0", bus.mem_req, bus.busy); else passes++;
    reset = 1'b0;
    bus.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.mem_ack = 1'b1;
      @(negedge clk);
      if (bus.done) dn++;
      if (bus.mem_req) rq++;
    end
    bus.mem_ack = 1'b0;
    checks++; if (dn !== 0 || rq !== 0) $display("FAIL rst_wr_quiet got done=%0d req=%0d want 0 0", dn, rq); else passes++;
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opcode = 8'hC7; bus.reg_rdata = 8'h00;
    @(posedge clk); #1;
    bus.opcode = 8'hDF; bus.reg_rdata = 8'hAA;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy1 got=%b want=1", bus.busy); else passes++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.reg_wdata !== 8'h01 || bus.reg_sel !== 3'd7) $display("FAIL b2b_first got done=%b d=%h sel=%0d want 1 01 7", bus.done, bus.reg_wdata, bus.reg_sel); else passes++;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opcode = 8'hCF; bus.reg_rdata = 8'h00;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL b2b_gap got busy=%b done=%b want 0 0", bus.busy, bus.done); else passes++;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.reg_rdata = 8'h5A;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept got=%b want=1", bus.busy); else passes++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.reg_wdata !== 8'h02) $display("FAIL b2b_second got done=%b d=%h want 1 02", bus.done, bus.reg_wdata); else passes++;
  endtask

  task automatic test_random();
    logic [7:0] op, rr, f, mrd, exp_res; logic [15:0] h;
    logic [1:0] cls; logic [2:0] sel; int dly, exp_cyc;
    logic illegal, is_mem, exp_regwe, exp_fwe, exp_rd, exp_wr;
    for (int i = 0; i < 40; i++) begin
      cls = 2'($urandom_range(0, 3));
      if (cls == 2'b00 && $urandom_range(0, 2) != 0) cls = 2'b11;
      is_mem = ($urandom_range(0, 1) == 1);
      sel = is_mem ? 3'd6 : 3'($urandom_range(0, 6));
      if (!is_mem && sel == 3'd6) sel = 3'd7;
      op = {cls, 3'($urandom_range(0, 7)), sel};
      rr = 8'($urandom); f = 8'($urandom); mrd = 8'($urandom); h = 16'($urandom);
      dly = $urandom_range(0, 3);
      illegal   = (cls == 2'b00);
      exp_cyc   = illegal ? 1 : (!is_mem ? 2 : (cls == 2'b01 ? dly + 3 : 2 * dly + 4));
      exp_res   = model(op, is_mem ? mrd : rr, f);
      exp_rd    = !illegal && is_mem;
      exp_wr    = !illegal && is_mem && cls != 2'b01;
      exp_regwe = !illegal && !is_mem && cls != 2'b01;
      exp_fwe   = (cls == 2'b01);
      run_op(op, rr, h, f, mrd, dly);
      checks++; if (done_cyc !== exp_cyc || n_done !== 1) $display("FAIL rnd%0d_done op=%h got cyc=%0d n=%0d want cyc=%0d n=1", i, op, done_cyc, n_done, exp_cyc); else passes++;
      checks++; if (n_err !== int'(illegal)) $display("FAIL rnd%0d_err op=%h got=%0d want=%0d", i, op, n_err, illegal); else passes++;
      checks++; if (n_regwe !== int'(exp_regwe) || n_fwe !== int'(exp_fwe)) $display("FAIL rnd%0d_strobes op=%h got rwe=%0d fwe=%0d want %0d %0d", i, op, n_regwe, n_fwe, exp_regwe, exp_fwe); else passes++;
      checks++; if (n_rd !== int'(exp_rd) || n_wr !== int'(exp_wr)) $display("FAIL rnd%0d_access op=%h got rd=%0d wr=%0d want %0d %0d", i, op, n_rd, n_wr, exp_rd, exp_wr); else passes++;
      checks++; if (n_req_bad !== 0 || n_stray !== 0) $display("FAIL rnd%0d_protocol op=%h got bad=%0d stray=%0d want 0 0", i, op, n_req_bad, n_stray); else passes++;
      if (exp_regwe) begin
        checks++; if (reg_wdata_v !== exp_res || reg_sel_v !== sel) $display("FAIL rnd%0d_reg op=%h got d=%h sel=%0d want %h %0d", i, op, reg_wdata_v, reg_sel_v, exp_res, sel); else passes++;
      end
      if (exp_fwe) begin
        checks++; if (f_out_v !== exp_res) $display("FAIL rnd%0d_flags op=%h got=%h want=%h", i, op, f_out_v, exp_res); else passes++;
      end
      if (exp_rd) begin
        checks++; if (rd_addr !== h) $display("FAIL rnd%0d_rdaddr got=%h want=%h", i, rd_addr, h); else passes++;
      end
      if (exp_wr) begin
        checks++; if (wr_addr !== h || wr_data !== exp_res) $display("FAIL rnd%0d_wr op=%h got a=%h d=%h want %h %h", i, op, wr_addr, wr_data, h, exp_res); else passes++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_reg_set();
    test_bit_reg();
    test_mem_res();
    test_mem_bit();
    test_illegal();
    test_reset_mid_wr();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
